// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants and types for the point-arithmetic datapath.
package fp32_pkg;

  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // Bit positions inside the {inv, dz, ovf, unf, inx} flag vector.
  localparam int unsigned FLAG_INV = 4;
  localparam int unsigned FLAG_DZ  = 3;
  localparam int unsigned FLAG_OVF = 2;
  localparam int unsigned FLAG_UNF = 1;
  localparam int unsigned FLAG_INX = 0;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  // Prefixed so the class names do not collide with the NORM state.
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; denormals (exponent 0) are treated as zero.
module fp_classify
  import fp32_pkg::*;
(
  input  logic [7:0]  exponent,
  input  logic [22:0] fraction,
  output fp_class_t   cls
);

  always_comb begin
    if (exponent == 8'd0) begin
      cls = CLS_ZERO;
    end else if (exponent == 8'(EXP_MAX)) begin
      cls = (fraction == 23'd0) ? CLS_INF : CLS_NAN;
    end else begin
      cls = CLS_NORM;
    end
  end

endmodule

// File: rtl/dividerunit.sv
// Iterative single-precision divider: restoring radix-2, one quotient bit per clock,
// flush-to-zero, optional round-to-nearest-even.
module dividerunit
  import fp32_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataR,
  output logic [4:0]  flags
);

  localparam logic [4:0]        LAST_ITER = 5'd25;
  localparam logic signed [9:0] BIAS_S    = signed'(10'(BIAS));
  localparam logic signed [9:0] EMAX_S    = signed'(10'(EXP_MAX));

  state_t      state;
  logic [4:0]  iter;
  logic        sign;
  logic [7:0]  ea, eb;
  logic [24:0] rem;
  logic [23:0] dvs;
  logic [25:0] q;

  fp_class_t cls_a, cls_b;

  fp_classify u_cls_a (
    .exponent (dataA[30:23]),
    .fraction (dataA[22:0]),
    .cls      (cls_a)
  );

  fp_classify u_cls_b (
    .exponent (dataB[30:23]),
    .fraction (dataB[22:0]),
    .cls      (cls_b)
  );

  // Special-operand result, evaluated on the live inputs while IDLE.
  logic        spec_hit, spec_sign;
  logic [31:0] spec_r;
  logic [4:0]  spec_f;

  always_comb begin
    spec_sign = dataA[31] ^ dataB[31];
    spec_hit  = (cls_a != CLS_NORM) || (cls_b != CLS_NORM);
    spec_r    = '0;
    spec_f    = '0;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
        (cls_a == CLS_INF && cls_b == CLS_INF)) begin
      spec_r           = QNAN;
      spec_f[FLAG_INV] = 1'b1;
    end else if (cls_a == CLS_INF) begin
      spec_r = {spec_sign, 8'hFF, 23'd0};
    end else if (cls_b == CLS_ZERO) begin
      spec_r          = {spec_sign, 8'hFF, 23'd0};
      spec_f[FLAG_DZ] = 1'b1;
    end else begin
      spec_r = {spec_sign, 31'd0};
    end
  end

  // One restoring step.
  logic        ge;
  logic [24:0] rem_sub, rem_nxt;

  always_comb begin
    ge      = rem >= {1'b0, dvs};
    rem_sub = ge ? rem - {1'b0, dvs} : rem;
    rem_nxt = rem_sub << 1;
  end

  // Normalise, round and range-check the finished quotient.
  logic signed [9:0] e_base, e_adj, e_fin;
  logic [22:0]       frac;
  logic [23:0]       frac_inc;
  logic              guard, sticky, rnd_up;
  logic [31:0]       norm_r;
  logic [4:0]        norm_f;

  always_comb begin
    e_base = signed'({2'b00, ea}) - signed'({2'b00, eb}) + BIAS_S;
    if (q[25]) begin
      frac   = q[24:2];
      guard  = q[1];
      sticky = q[0] | (|rem);
      e_adj  = e_base;
    end else begin
      frac   = q[23:1];
      guard  = q[0];
      sticky = |rem;
      e_adj  = e_base - 10'sd1;
    end
    rnd_up   = ROUND_EN && guard && (sticky || frac[0]);
    frac_inc = {1'b0, frac} + 24'(rnd_up);
    e_fin    = frac_inc[23] ? e_adj + 10'sd1 : e_adj;
    norm_r   = {sign, e_fin[7:0], frac_inc[22:0]};
    norm_f   = '0;
    norm_f[FLAG_INX] = guard | sticky;
    if (e_fin >= EMAX_S) begin
      norm_r           = {sign, 8'hFF, 23'd0};
      norm_f[FLAG_OVF] = 1'b1;
      norm_f[FLAG_INX] = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      norm_r           = {sign, 31'd0};
      norm_f[FLAG_UNF] = 1'b1;
      norm_f[FLAG_INX] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      iter  <= '0;
      sign  <= 1'b0;
      ea    <= '0;
      eb    <= '0;
      rem   <= '0;
      dvs   <= '0;
      q     <= '0;
      done  <= 1'b0;
      dataR <= '0;
      flags <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sign <= spec_sign;
            ea   <= dataA[30:23];
            eb   <= dataB[30:23];
            rem  <= {2'b01, dataA[22:0]};
            dvs  <= {1'b1, dataB[22:0]};
            q    <= '0;
            iter <= '0;
            if (spec_hit) begin
              dataR <= spec_r;
              flags <= spec_f;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          q    <= {q[24:0], ge};
          rem  <= rem_nxt;
          iter <= iter + 5'd1;
          if (iter == LAST_ITER) state <= NORM;
        end
        NORM: begin
          dataR <= norm_r;
          flags <= norm_f;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dividerunit.sv
// Scoreboard bench for dividerunit: rounded and truncating instances run in lockstep.
module tb_dividerunit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        busy, done, busy_t, done_t;
  logic [31:0] data_r, data_r_t;
  logic [4:0]  flags, flags_t;

  dividerunit #(.ROUND_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dataA(data_a), .dataB(data_b),
    .busy(busy), .done(done), .dataR(data_r), .flags(flags)
  );

  dividerunit #(.ROUND_EN(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start), .dataA(data_a), .dataB(data_b),
    .busy(busy_t), .done(done_t), .dataR(data_r_t), .flags(flags_t)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r_rn;
    logic [4:0]  f_rn;
    logic [31:0] r_tr;
    logic [4:0]  f_tr;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return a[30:23] == 8'd0 || a[30:23] == 8'hFF || b[30:23] == 8'd0 || b[30:23] == 8'hFF;
  endfunction

  // Reference: exact integer quotient of the significands, then rounded from its tail.
  function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit rnd);
    logic s;
    int ea, eb, e, sh;
    bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, rem_nz, inexact;
    longint unsigned num, den, qv, keep, lost, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = ea == 0;
    b_zero = eb == 0;
    a_inf  = ea == 255 && a[22:0] == 0;
    b_inf  = eb == 255 && b[22:0] == 0;
    a_nan  = ea == 255 && a[22:0] != 0;
    b_nan  = eb == 255 && b[22:0] != 0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {5'b10000, 32'h7FC00000};
    if (a_inf) return {5'b00000, s, 8'hFF, 23'd0};
    if (b_zero) return {5'b01000, s, 8'hFF, 23'd0};
    if (a_zero || b_inf) return {5'b00000, s, 31'd0};
    num    = (longint'(a[22:0]) + 64'd8388608) << 25;
    den    = longint'(b[22:0]) + 64'd8388608;
    qv     = num / den;
    rem_nz = (num % den) != 0;
    e      = ea - eb + 127;
    if (qv >= 64'd33554432) sh = 2;
    else begin
      sh = 1;
      e  = e - 1;
    end
    keep    = qv >> sh;
    lost    = qv - (keep << sh);
    half    = 64'd1 << (sh - 1);
    inexact = lost != 0 || rem_nz;
    if (rnd && (lost > half || (lost == half && (rem_nz || keep[0])))) keep = keep + 1;
    if (keep >= 64'd16777216) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
    if (e <= 0) return {5'b00011, s, 31'd0};
    return {4'b0000, inexact, s, e[7:0], keep[22:0]};
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input bit use_k,
                          input logic [31:0] kr, input logic [4:0] kf, input logic [31:0] kt);
    exp_t e;
    logic [36:0] m;
    m      = ref_div(a, b, 1'b1);
    e.r_rn = use_k ? kr : m[31:0];
    e.f_rn = use_k ? kf : m[36:32];
    m      = ref_div(a, b, 1'b0);
    e.r_tr = use_k ? kt : m[31:0];
    e.f_tr = m[36:32];
    e.lat  = is_special(a, b) ? 0 : 27;
    e.t0   = cyc;
    sb.push_back(e);
  endtask

  // Bounded wait for the unit to go idle; optionally disturbs inputs while busy.
  task automatic wait_idle(input bit disturb);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
      if (disturb && n < 20) begin
        data_a = $urandom;
        data_b = $urandom;
        start  = (n % 3 == 0);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit use_k,
                       input logic [31:0] kr, input logic [4:0] kf, input logic [31:0] kt,
                       input bit disturb);
    @(negedge clk);
    data_a = a;
    data_b = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(a, b, use_k, kr, kf, kt);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_idle(disturb);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("dataR", data_r, e.r_rn);
        check("flags", 32'(flags), 32'(e.f_rn));
        check("dataR_trunc", data_r_t, e.r_tr);
        check("flags_trunc", 32'(flags_t), 32'(e.f_tr));
        check("done_trunc", 32'(done_t), 32'd1);
        check("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 9) == 0) v[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
    else v[30:23] = 8'($urandom_range(1, 254));
    if ($urandom_range(0, 7) == 0) v[22:0] = '0;
    return v;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] a, b;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dataR", data_r, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 5'b00000, 32'h40400000, 1'b0);
    issue(32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB, 5'b00001, 32'h3EAAAAAA, 1'b0);
    issue(32'hBF800000, 32'h00000000, 1'b1, 32'hFF800000, 5'b01000, 32'hFF800000, 1'b0);
    issue(32'h00000000, 32'h00000000, 1'b1, 32'h7FC00000, 5'b10000, 32'h7FC00000, 1'b0);
    issue(32'h7F7FFFFF, 32'h3F000000, 1'b1, 32'h7F800000, 5'b00101, 32'h7F800000, 1'b0);
    issue(32'h00800000, 32'h40000000, 1'b1, 32'h00000000, 5'b00011, 32'h00000000, 1'b0);
    issue(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 5'b00000, 32'h40400000, 1'b1);

    // Start held through the done cycle: ignored there, accepted one cycle later.
    @(negedge clk);
    data_a = 32'h40C00000;
    data_b = 32'h40000000;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(32'h40C00000, 32'h40000000, 1'b0, '0, '0, '0);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    data_a = 32'h3F800000;
    data_b = 32'h40400000;
    start  = 1'b1;
    @(posedge clk);
    #1;
    check("start_in_done_ignored", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(32'h3F800000, 32'h40400000, 1'b0, '0, '0, '0);
    check("start_after_done_accepted", 32'(busy), 32'd1);
    wait_idle(1'b0);

    // Abort at iteration 10.
    @(negedge clk);
    data_a = 32'h40490FDB;
    data_b = 32'h402DF854;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dataR", data_r, 32'd0);
    check("abort_dataR_trunc", data_r_t, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h40490FDB, 32'h402DF854, 1'b0, '0, '0, '0, 1'b0);

    for (int i = 0; i < 48; i++) begin
      a = rand_op();
      b = rand_op();
      issue(a, b, 1'b0, '0, '0, '0, (i % 4 == 0) && !is_special(a, b));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dividerunit.md
# dividerunit

Iterative IEEE-754 single-precision divider, the inverse operation to the floating-point multiplier unit in the point-arithmetic datapath.
- Computes dataR = dataA / dataB with a restoring radix-2 mantissa divider, producing one quotient bit per clock.
- Operands are captured on a start pulse; a one-cycle done pulse marks a held, registered result.
- Denormals are flushed to zero and rounding is round-to-nearest-even.

## Interface
- ROUND_EN, 1: 1 = round-to-nearest-even; 0 = truncate (inx still reported).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- dataA  in  32  dividend, IEEE-754 single.
- dataB  in  32  divisor, IEEE-754 single.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, result valid.
- dataR  out  32  quotient, registered, held until the next accepted start.
- flags  out  5  {inv, dz, ovf, unf, inx}, registered alongside dataR.

## Operation
- States: IDLE, DIV, NORM, DONE.
  - IDLE -> DONE on start with a special operand.
  - IDLE -> DIV on start otherwise.
  - DIV -> NORM after 26 iterations.
  - NORM -> DONE.
  - DONE -> IDLE unconditionally.
- On start, latch the sign (sA ^ sB), both exponents and both mantissas. Later changes on dataA/dataB have no effect.
- Operand classes: exponent 0 is zero (fraction ignored); exponent 255 with fraction 0 is inf; exponent 255 with fraction != 0 is NaN.
- Special results, each with the computed sign unless noted:
  - NaN operand, 0/0, or inf/inf: 0x7FC00000, inv.
  - finite/0: signed inf, dz.
  - 0/finite or finite/inf: signed zero.
  - inf/finite: signed inf.
- Divider datapath:
  - Init: R = {1,mA} (25 b), D = {1,mB}.
  - Each DIV cycle: if R >= D then q bit = 1 and R = R - D, else q bit = 0; then R = R << 1. 26 bits are produced, MSB first, into q[25:0].
- Normalisation (NORM), with E = eA - eB + 127 as a signed 10-bit value:
  - If q[25] = 1: frac = q[24:2], guard = q[1], sticky = q[0] | (R != 0).
  - Otherwise: frac = q[23:1], guard = q[0], sticky = (R != 0), and E = E - 1.
- Rounding:
  - Round up when guard & (sticky | frac[0]).
  - A carry out of frac increments E and zeroes frac.
  - inx = guard | sticky.
- Range checks:
  - E >= 255: signed inf, ovf and inx.
  - E <= 0: signed zero, unf and inx.

## Timing
- Reset values: state IDLE, busy 0, done 0, dataR 0x00000000, flags 0.
- Let E0 be the edge that samples start.
  - Special case: done is high in the cycle after E0 (latency 1).
  - Normal case: iterations occur on E1..E26, NORM is entered after E26, and dataR/flags load with done high after E27 (latency 27).
- busy covers every non-IDLE cycle, including DONE.
- start while busy is ignored; no queuing.
- start in the cycle done is high is ignored; it is accepted the following cycle.
- rst_n low mid-operation aborts immediately to reset values. No done pulse is issued for the aborted operation.

## Structure
- Package fp32_pkg holds:
  - BIAS = 127, EXP_MAX = 255, QNAN = 32'h7FC00000.
  - Flag index constants.
  - Enum state_t {IDLE, DIV, NORM, DONE}.
  - Operand class enum {ZERO, NORM, INF, NAN}.
- Sub-module fp_classify: combinational classification of one operand. It is instantiated twice and is reusable by the multiplier unit.
- FSM, iteration counter (5 b), divider datapath and normaliser stay in dividerunit.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) -> 0x40400000, flags 0, done 27 edges after start.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, inx = 1. With ROUND_EN = 0 -> 0x3EAAAAAA.
- 0xBF800000 / 0x00000000 -> 0xFF800000, dz = 1, latency 1. 0/0 -> 0x7FC00000, inv = 1.
- 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, ovf = 1. 0x00800000 / 0x40000000 -> 0x00000000, unf = 1.
- Reset mid-operation: rst_n low at iteration 10 -> busy 0, done 0, dataR 0. A fresh start afterwards completes correctly.
- start re-pulsed while busy, and operands changed mid-operation -> result and latency unaffected.
